fetch_unit: RTL and testbench

Instruction-fetch front end feeding the decode stage of the RV32I core. Takes the decode stage's program counter, issues one word read per instruction on the instruction-memory request/acknowledge interface, and presents the fetched word with a one-cycle-per-consumption enable (`o_EN`) that drives decode's `i_INSTRUCTION`/`i_EN`. Handles downstream stall, redirect flush with in-flight response discard, misaligned PCs and, optionally, a memory-response watchdog.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_watchdog.sv | 30 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch FSM state encoding and the default fault-substitute word
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } fetch_state_t;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/acknowledge bus
interface fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - memory-response wait counter with single-cycle expiry pulse
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_CLK,
    input  logic i_RSTn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the last permitted waiting cycle so the FSM leaves on the next edge.
    assign expire = enable && (count == LAST);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch front end; optional watchdog under FETCH_WATCHDOG_EN
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_STALL,
    input  logic        i_FLUSH,
    fetch_unit_if.master imem,
    output logic [31:0] o_INSTRUCTION,
    output logic [31:0] o_PC_FETCHED,
    output logic        o_EN,
    output logic        o_FAULT
);

    fetch_state_t state;
    logic [31:0]  addr_q;
    logic         misaligned;
    logic         wd_expire;

    assign misaligned = (i_PC[1:0] != 2'b00);
    assign imem.addr  = {i_PC[31:2], 2'b00};
    assign imem.req   = i_RSTn && (state == S_REQ) && !i_FLUSH && !misaligned;
    assign o_EN       = (state == S_VALID) && !i_STALL && !i_FLUSH;

`ifdef FETCH_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    // Clear on every entry into a waiting state: a new request, or a flush that starts draining.
    assign wd_clear  = imem.req || ((state == S_WAIT) && i_FLUSH && !imem.ack);
    assign wd_enable = ((state == S_WAIT) || (state == S_DRAIN)) && !imem.ack;

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state         <= S_REQ;
            addr_q        <= '0;
            o_INSTRUCTION <= NOP_INSTR;
            o_PC_FETCHED  <= '0;
            o_FAULT       <= 1'b0;
        end else begin
            o_FAULT <= 1'b0;
            case (state)
                S_REQ: begin
                    if (!i_FLUSH) begin
                        if (misaligned) begin
                            o_INSTRUCTION <= NOP_INSTR;
                            o_PC_FETCHED  <= i_PC;
                            o_FAULT       <= 1'b1;
                            state         <= S_VALID;
                        end else begin
                            addr_q <= imem.addr;
                            state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem.ack) begin
                        if (i_FLUSH) begin
                            state <= S_REQ;
                        end else begin
                            o_INSTRUCTION <= imem.rdata;
                            o_PC_FETCHED  <= addr_q;
                            state         <= S_VALID;
                        end
                    end else if (i_FLUSH) begin
                        state <= S_DRAIN;
                    end else if (wd_expire) begin
                        o_INSTRUCTION <= NOP_INSTR;
                        o_PC_FETCHED  <= addr_q;
                        o_FAULT       <= 1'b1;
                        state         <= S_VALID;
                    end
                end
                S_DRAIN: begin
                    // The outstanding response must be swallowed before a new request may issue.
                    if (imem.ack || wd_expire) begin
                        state <= S_REQ;
                    end
                end
                S_VALID: begin
                    if (o_EN || i_FLUSH) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed-vector bench for fetch_unit
module tb_fetch_unit;

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_fetched;
    logic        en;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit_if bus();

    fetch_unit #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK         (clk),
        .i_RSTn        (rst_n),
        .i_PC          (pc),
        .i_STALL       (stall),
        .i_FLUSH       (flush),
        .imem          (bus),
        .o_INSTRUCTION (instr),
        .o_PC_FETCHED  (pc_fetched),
        .o_EN          (en),
        .o_FAULT       (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;

        tick(); tick(); #1;
        check("rst_req",   32'(bus.req), 32'd0);
        check("rst_en",    32'(en), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pcf",   pc_fetched, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);

        // basic fetch, 1-cycle memory
        tick(); rst_n = 1'b1; #1;
        check("t1_req",  32'(bus.req), 32'd1);
        check("t1_addr", bus.addr, 32'h0);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0050_0093; #1;
        check("t1_wait_req", 32'(bus.req), 32'd0);
        check("t1_wait_en",  32'(en), 32'd0);
        tick(); bus.ack = 1'b0; #1;
        check("t1_en",    32'(en), 32'd1);
        check("t1_instr", instr, 32'h0050_0093);
        check("t1_pcf",   pc_fetched, 32'h0);
        pc = 32'h4;

        // stall held for 4 cycles in S_VALID
        tick(); #1;
        check("t2_req",  32'(bus.req), 32'd1);
        check("t2_addr", bus.addr, 32'h4);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0010_0113; #1;
        tick(); bus.ack = 1'b0; stall = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick(); #1;
            end
            check("t2_stall_en",    32'(en), 32'd0);
            check("t2_stall_req",   32'(bus.req), 32'd0);
            check("t2_stall_instr", instr, 32'h0010_0113);
        end
        tick(); stall = 1'b0; #1;
        check("t2_rel_en",  32'(en), 32'd1);
        check("t2_rel_pcf", pc_fetched, 32'h4);
        pc = 32'h8;
        tick(); #1;
        check("t2_next_req",  32'(bus.req), 32'd1);
        check("t2_next_addr", bus.addr, 32'h8);

        // flush in S_WAIT, response arrives 3 cycles later and is dropped
        tick(); flush = 1'b1; pc = 32'h100; #1;
        check("t3_flush_en", 32'(en), 32'd0);
        tick(); flush = 1'b0; #1;
        check("t3_d1_req", 32'(bus.req), 32'd0);
        tick(); #1;
        check("t3_d2_req", 32'(bus.req), 32'd0);
        check("t3_d2_en",  32'(en), 32'd0);
        tick(); bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF; #1;
        check("t3_d3_req", 32'(bus.req), 32'd0);
        check("t3_d3_en",  32'(en), 32'd0);
        tick(); bus.ack = 1'b0; #1;
        check("t3_req",   32'(bus.req), 32'd1);
        check("t3_addr",  bus.addr, 32'h100);
        check("t3_en",    32'(en), 32'd0);
        check("t3_instr", instr, 32'h0010_0113);

        // flush coincident with ack
        tick(); bus.ack = 1'b1; flush = 1'b1; bus.rdata = 32'hCAFE_F00D; #1;
        check("t4_en", 32'(en), 32'd0);
        tick(); bus.ack = 1'b0; flush = 1'b0; #1;
        check("t4_req",   32'(bus.req), 32'd1);
        check("t4_addr",  bus.addr, 32'h100);
        check("t4_instr", instr, 32'h0010_0113);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0020_8193; #1;
        tick(); bus.ack = 1'b0; #1;
        check("t4b_en",    32'(en), 32'd1);
        check("t4b_instr", instr, 32'h0020_8193);
        check("t4b_pcf",   pc_fetched, 32'h100);
        pc = 32'h6;

        // misaligned PC
        tick(); #1;
        check("t5_req",       32'(bus.req), 32'd0);
        check("t5_fault_pre", 32'(fault), 32'd0);
        tick(); #1;
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_instr", instr, NOP);
        check("t5_pcf",   pc_fetched, 32'h6);
        check("t5_en",    32'(en), 32'd1);
        pc = 32'h104;
        tick(); #1;
        check("t5_fault_clr", 32'(fault), 32'd0);
        check("t5_next_req",  32'(bus.req), 32'd1);
        check("t5_next_addr", bus.addr, 32'h104);

        // flush while presenting
        tick(); bus.ack = 1'b1; bus.rdata = 32'h1111_1111; #1;
        tick(); bus.ack = 1'b0; flush = 1'b1; #1;
        check("t6_en", 32'(en), 32'd0);
        tick(); flush = 1'b0; #1;
        check("t6_req",  32'(bus.req), 32'd1);
        check("t6_addr", bus.addr, 32'h104);
        tick(); #1;

        // no response from memory
`ifdef FETCH_WATCHDOG_EN
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                tick(); #1;
            end
            check("wd_wait_fault", 32'(fault), 32'd0);
            check("wd_wait_en",    32'(en), 32'd0);
        end
        tick(); bus.ack = 1'b1; bus.rdata = 32'hBAD0_BAD0; #1;
        check("wd_fault", 32'(fault), 32'd1);
        check("wd_instr", instr, NOP);
        check("wd_pcf",   pc_fetched, 32'h104);
        check("wd_en",    32'(en), 32'd1);
        pc = 32'h108;
        tick(); bus.ack = 1'b0; #1;
        check("wd_next_req",  32'(bus.req), 32'd1);
        check("wd_next_addr", bus.addr, 32'h108);
        tick(); #1;
        check("wd_late_en",    32'(en), 32'd0);
        check("wd_late_instr", instr, NOP);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0040_0313; #1;
        tick(); bus.ack = 1'b0; #1;
        check("wd_resume_en",    32'(en), 32'd1);
        check("wd_resume_instr", instr, 32'h0040_0313);
        check("wd_resume_pcf",   pc_fetched, 32'h108);
`else
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                tick(); #1;
            end
            check("nowd_wait_fault", 32'(fault), 32'd0);
            check("nowd_wait_en",    32'(en), 32'd0);
        end
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0040_0313; #1;
        tick(); bus.ack = 1'b0; #1;
        check("nowd_en",    32'(en), 32'd1);
        check("nowd_instr", instr, 32'h0040_0313);
        check("nowd_pcf",   pc_fetched, 32'h104);
        pc = 32'h108;
`endif

        // reset mid-fetch, late ack after release is ignored
        tick(); #1;
        check("r2_req", 32'(bus.req), 32'd1);
        tick(); rst_n = 1'b0; #1;
        check("r2_rst_req",   32'(bus.req), 32'd0);
        check("r2_rst_en",    32'(en), 32'd0);
        check("r2_rst_instr", instr, NOP);
        check("r2_rst_pcf",   pc_fetched, 32'h0);
        tick(); rst_n = 1'b1; bus.ack = 1'b1; bus.rdata = 32'hBAAD_F00D; pc = 32'h200; #1;
        check("r2_req_after",  32'(bus.req), 32'd1);
        check("r2_addr_after", bus.addr, 32'h200);
        tick(); bus.ack = 1'b0; #1;
        check("r2_wait_en", 32'(en), 32'd0);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0030_0293; #1;
        tick(); bus.ack = 1'b0; #1;
        check("r2_en",    32'(en), 32'd1);
        check("r2_instr", instr, 32'h0030_0293);
        check("r2_pcf",   pc_fetched, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
